id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register that produces every operand and control input consumed by the execute stage: read data, immediate, PC, opcode, ALUOp, ALUSrc, plus the downstream memory and writeback controls. Sits between decode and execute. It also holds the load-use hazard detector, which inserts a one-cycle bubble and asks the fetch/decode registers to hold. External stall and flush inputs come from the branch and memory logic.

Parameters:
DATA_W, 64, width of register-file data, immediate and PC
BUBBLE_CNT_W, 32, width of the saturating bubble counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
id_valid  input  1  decode stage holds a real instruction
id_ReadData1  input  DATA_W  Rn read data
id_ReadData2  input  DATA_W  Rm/Rt read data
id_Immediate  input  DATA_W  sign-extended immediate
id_PC  input  DATA_W  PC of the decoded instruction
id_Opcode  input  11  instruction[31:21]
id_Rn, id_Rm, id_Rd  input  5 each  register indices (id_Rm is Rt for CBZ/STUR)
id_ALUOp  input  2  00 add (LDUR/STUR), 01 pass B (CBZ), 10 R-type
id_ALUSrc, id_MemRead, id_MemWrite, id_MemtoReg, id_RegWrite, id_Branch  input  1 each  decode controls
id_uses_Rm  input  1  instruction reads Rm/Rt (R-type, STUR, CBZ)
stall  input  1  external hold (downstream not ready)
flush  input  1  squash the instruction entering EX (taken branch)
ex_valid  output  1  EX holds a real instruction
ALUReadData1, ALUReadData2, Immediate, PC  output  DATA_W  registered operands to execute
Opcode  output  11  registered opcode
ALUOp  output  2  registered ALUOp
ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, Branch  output  1 each  registered controls
ex_Rn, ex_Rm, ex_Rd  output  5 each  registered indices for forwarding
hazard_stall  output  1  combinational; tells PC and IF/ID to hold this cycle
bubble_count  output  BUBBLE_CNT_W  bubbles inserted since reset

Behaviour:
- Reset (async, immediate): every output register goes to 0, including ex_valid, all controls, data, indices and bubble_count. hazard_stall is 0 while reset is asserted.
- Load-use hazard, combinational: hazard_stall = ex_valid & MemRead & id_valid & (ex_Rd != 31) & ((ex_Rd == id_Rn) | (id_uses_Rm & ex_Rd == id_Rm)). Register 31 (XZR) never causes a hazard.
- Priority at each rising edge, highest first:
  1. flush: load a bubble.
  2. stall: hold every output register unchanged.
  3. hazard_stall: load a bubble.
  4. Otherwise: capture all id_* fields. ex_valid <= id_valid.
- Bubble: ex_valid, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite and Branch go to 0. ALUOp <= 00, Opcode <= 0, indices <= 0. Data fields go to 0.
- Latency: exactly one cycle from id_* to outputs. No combinational path from id_* to the registered outputs.
- hazard_stall is suppressed (forced 0) when flush or stall is 1. Under stall the EX contents are frozen, so re-evaluation happens next cycle.
- A load-use stall lasts exactly one cycle. After the bubble, MemRead=0 in EX, so hazard_stall drops and the held decode instruction is captured on the next edge.
- If id_valid=0 and nothing else is asserted, the register captures a non-valid entry: ex_valid=0, controls pass through as driven. This is not counted as a bubble.
- bubble_count increments by 1 on every edge that loads a bubble (rule 1 or 3). It saturates at all-ones and does not change on stall.
- Reset mid-operation clears everything immediately, including a pending hazard. The first edge after reset deasserts follows the normal rules.

Test Plan:
- Reset: assert reset with id fields non-zero -> all outputs 0, bubble_count=0, hazard_stall=0, asynchronously and without a clock edge.
- Pass-through: id_ALUOp=10, Opcode=11'b10001011000 (ADD), ReadData1=2, ReadData2=3, Immediate=1, PC=16, ALUSrc=0, id_valid=1 -> after one edge the outputs match exactly and ex_valid=1.
- Load-use: EX holds LDUR (MemRead=1, ex_Rd=5); decode presents ADD with id_Rn=5 -> hazard_stall=1, the next edge gives ex_valid=0 with zero controls, bubble_count=1, and the edge after that captures the ADD. Repeat with ex_Rd=31 -> no stall.
- Stall hold: load CBZ (ALUOp=01, Branch=1, ReadData2=3), then stall=1 for 3 edges while the id fields change -> outputs remain CBZ values and bubble_count is unchanged.
- Flush vs stall: flush=1 and stall=1 on the same edge -> bubble loaded, bubble_count increments, hazard_stall=0.
- Saturation: preload with BUBBLE_CNT_W=2, force 5 flushes -> bubble_count reads 3 and stays there.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Priority per edge: flush bubble, then external stall hold, then load-use bubble, then capture.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned BUBBLE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [DATA_W-1:0]       id_ReadData1,
  input  logic [DATA_W-1:0]       id_ReadData2,
  input  logic [DATA_W-1:0]       id_Immediate,
  input  logic [DATA_W-1:0]       id_PC,
  input  logic [10:0]             id_Opcode,
  input  logic [4:0]              id_Rn,
  input  logic [4:0]              id_Rm,
  input  logic [4:0]              id_Rd,
  input  logic [1:0]              id_ALUOp,
  input  logic                    id_ALUSrc,
  input  logic                    id_MemRead,
  input  logic                    id_MemWrite,
  input  logic                    id_MemtoReg,
  input  logic                    id_RegWrite,
  input  logic                    id_Branch,
  input  logic                    id_uses_Rm,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    ex_valid,
  output logic [DATA_W-1:0]       ALUReadData1,
  output logic [DATA_W-1:0]       ALUReadData2,
  output logic [DATA_W-1:0]       Immediate,
  output logic [DATA_W-1:0]       PC,
  output logic [10:0]             Opcode,
  output logic [1:0]              ALUOp,
  output logic                    ALUSrc,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic                    MemtoReg,
  output logic                    RegWrite,
  output logic                    Branch,
  output logic [4:0]              ex_Rn,
  output logic [4:0]              ex_Rm,
  output logic [4:0]              ex_Rd,
  output logic                    hazard_stall,
  output logic [BUBBLE_CNT_W-1:0] bubble_count
);

  localparam logic [4:0]              Xzr    = 5'd31;
  localparam logic [BUBBLE_CNT_W-1:0] CntOne = BUBBLE_CNT_W'(1);

  logic                    ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0]       rd1_q, rd1_d;
  logic [DATA_W-1:0]       rd2_q, rd2_d;
  logic [DATA_W-1:0]       imm_q, imm_d;
  logic [DATA_W-1:0]       pc_q, pc_d;
  logic [10:0]             opcode_q, opcode_d;
  logic [1:0]              alu_op_q, alu_op_d;
  logic                    alu_src_q, alu_src_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic                    mem_to_reg_q, mem_to_reg_d;
  logic                    reg_write_q, reg_write_d;
  logic                    branch_q, branch_d;
  logic [4:0]              rn_q, rn_d;
  logic [4:0]              rm_q, rm_d;
  logic [4:0]              rd_q, rd_d;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic load_use;
  logic load_bubble;

  always_comb begin
    load_use = ex_valid_q & mem_read_q & id_valid & (rd_q != Xzr) &
               ((rd_q == id_Rn) | (id_uses_Rm & (rd_q == id_Rm)));
    // Under stall/flush the EX entry is frozen or squashed, so no decode hold is requested.
    hazard_stall = load_use & ~flush & ~stall & ~reset;
    load_bubble  = flush | (~stall & load_use);
  end

  always_comb begin
    ex_valid_d   = ex_valid_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    imm_d        = imm_q;
    pc_d         = pc_q;
    opcode_d     = opcode_q;
    alu_op_d     = alu_op_q;
    alu_src_d    = alu_src_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    branch_d     = branch_q;
    rn_d         = rn_q;
    rm_d         = rm_q;
    rd_d         = rd_q;
    bubble_cnt_d = bubble_cnt_q;

    if (load_bubble) begin
      ex_valid_d   = 1'b0;
      rd1_d        = '0;
      rd2_d        = '0;
      imm_d        = '0;
      pc_d         = '0;
      opcode_d     = '0;
      alu_op_d     = '0;
      alu_src_d    = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      reg_write_d  = 1'b0;
      branch_d     = 1'b0;
      rn_d         = '0;
      rm_d         = '0;
      rd_d         = '0;
      if (bubble_cnt_q != '1) begin
        bubble_cnt_d = bubble_cnt_q + CntOne;
      end
    end else if (!stall) begin
      ex_valid_d   = id_valid;
      rd1_d        = id_ReadData1;
      rd2_d        = id_ReadData2;
      imm_d        = id_Immediate;
      pc_d         = id_PC;
      opcode_d     = id_Opcode;
      alu_op_d     = id_ALUOp;
      alu_src_d    = id_ALUSrc;
      mem_read_d   = id_MemRead;
      mem_write_d  = id_MemWrite;
      mem_to_reg_d = id_MemtoReg;
      reg_write_d  = id_RegWrite;
      branch_d     = id_Branch;
      rn_d         = id_Rn;
      rm_d         = id_Rm;
      rd_d         = id_Rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      opcode_q     <= '0;
      alu_op_q     <= '0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      rn_q         <= '0;
      rm_q         <= '0;
      rd_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      opcode_q     <= opcode_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      branch_q     <= branch_d;
      rn_q         <= rn_d;
      rm_q         <= rm_d;
      rd_q         <= rd_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ALUReadData1 = rd1_q;
  assign ALUReadData2 = rd2_q;
  assign Immediate    = imm_q;
  assign PC           = pc_q;
  assign Opcode       = opcode_q;
  assign ALUOp        = alu_op_q;
  assign ALUSrc       = alu_src_q;
  assign MemRead      = mem_read_q;
  assign MemWrite     = mem_write_q;
  assign MemtoReg     = mem_to_reg_q;
  assign RegWrite     = reg_write_q;
  assign Branch       = branch_q;
  assign ex_Rn        = rn_q;
  assign ex_Rm        = rm_q;
  assign ex_Rd        = rd_q;
  assign bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: a behavioural EX-stage model pushes expected state per
// edge; a second instance with a 2-bit counter exercises saturation.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [63:0] pc;
    logic [10:0] opcode;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        branch;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rd;
  } ex_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [63:0] pc;
    logic [10:0] opcode;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rd;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        branch;
    logic        uses_rm;
  } id_t;

  typedef struct packed {
    ex_t         ex;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic stall, flush, flush_s;
  id_t  id, id_z;

  logic        ex_valid, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, hazard;
  logic [63:0] rd1, rd2, imm, pc;
  logic [10:0] opcode;
  logic [1:0]  alu_op;
  logic [4:0]  ex_rn, ex_rm, ex_rd;
  logic [31:0] bcnt;

  logic        s_valid, s_alu_src, s_mem_read, s_mem_write, s_mem_to_reg, s_reg_write;
  logic        s_branch, s_hazard;
  logic [63:0] s_rd1, s_rd2, s_imm, s_pc;
  logic [10:0] s_opcode;
  logic [1:0]  s_alu_op;
  logic [4:0]  s_rn, s_rm, s_rd;
  logic [1:0]  s_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  ex_t  m;
  logic [31:0] m_cnt;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .reset(reset), .id_valid(id.valid),
    .id_ReadData1(id.rd1), .id_ReadData2(id.rd2), .id_Immediate(id.imm), .id_PC(id.pc),
    .id_Opcode(id.opcode), .id_Rn(id.rn), .id_Rm(id.rm), .id_Rd(id.rd),
    .id_ALUOp(id.alu_op), .id_ALUSrc(id.alu_src), .id_MemRead(id.mem_read),
    .id_MemWrite(id.mem_write), .id_MemtoReg(id.mem_to_reg), .id_RegWrite(id.reg_write),
    .id_Branch(id.branch), .id_uses_Rm(id.uses_rm), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ALUReadData1(rd1), .ALUReadData2(rd2), .Immediate(imm), .PC(pc),
    .Opcode(opcode), .ALUOp(alu_op), .ALUSrc(alu_src), .MemRead(mem_read),
    .MemWrite(mem_write), .MemtoReg(mem_to_reg), .RegWrite(reg_write), .Branch(branch),
    .ex_Rn(ex_rn), .ex_Rm(ex_rm), .ex_Rd(ex_rd), .hazard_stall(hazard), .bubble_count(bcnt)
  );

  id_ex_pipe_reg #(.DATA_W(64), .BUBBLE_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_z.valid),
    .id_ReadData1(id_z.rd1), .id_ReadData2(id_z.rd2), .id_Immediate(id_z.imm),
    .id_PC(id_z.pc), .id_Opcode(id_z.opcode), .id_Rn(id_z.rn), .id_Rm(id_z.rm),
    .id_Rd(id_z.rd), .id_ALUOp(id_z.alu_op), .id_ALUSrc(id_z.alu_src),
    .id_MemRead(id_z.mem_read), .id_MemWrite(id_z.mem_write),
    .id_MemtoReg(id_z.mem_to_reg), .id_RegWrite(id_z.reg_write), .id_Branch(id_z.branch),
    .id_uses_Rm(id_z.uses_rm), .stall(1'b0), .flush(flush_s),
    .ex_valid(s_valid), .ALUReadData1(s_rd1), .ALUReadData2(s_rd2), .Immediate(s_imm),
    .PC(s_pc), .Opcode(s_opcode), .ALUOp(s_alu_op), .ALUSrc(s_alu_src),
    .MemRead(s_mem_read), .MemWrite(s_mem_write), .MemtoReg(s_mem_to_reg),
    .RegWrite(s_reg_write), .Branch(s_branch), .ex_Rn(s_rn), .ex_Rm(s_rm), .ex_Rd(s_rd),
    .hazard_stall(s_hazard), .bubble_count(s_cnt)
  );

  function automatic ex_t obs_ex();
    ex_t o;
    o = '{valid: ex_valid, rd1: rd1, rd2: rd2, imm: imm, pc: pc, opcode: opcode,
          alu_op: alu_op, alu_src: alu_src, mem_read: mem_read, mem_write: mem_write,
          mem_to_reg: mem_to_reg, reg_write: reg_write, branch: branch,
          rn: ex_rn, rm: ex_rm, rd: ex_rd};
    return o;
  endfunction

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hazard();
    return m.valid & m.mem_read & id.valid & (m.rd != 5'd31) &
           ((m.rd == id.rn) | (id.uses_rm & (m.rd == id.rm))) & ~flush & ~stall;
  endfunction

  function automatic ex_t capture(input id_t d);
    ex_t e;
    e = '{valid: d.valid, rd1: d.rd1, rd2: d.rd2, imm: d.imm, pc: d.pc, opcode: d.opcode,
          alu_op: d.alu_op, alu_src: d.alu_src, mem_read: d.mem_read,
          mem_write: d.mem_write, mem_to_reg: d.mem_to_reg, reg_write: d.reg_write,
          branch: d.branch, rn: d.rn, rm: d.rm, rd: d.rd};
    return e;
  endfunction

  // Inputs are already driven; checks hazard_stall, advances the model, compares after the edge.
  task automatic step(input string tag);
    logic hz;
    exp_t e;
    #1;
    hz = model_hazard();
    check_eq({tag, "/hz"}, {511'd0, hazard}, {511'd0, hz});
    if (flush || (!stall && hz)) begin
      m = '0;
      if (m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 1;
    end else if (!stall) begin
      m = capture(id);
    end
    sb_q.push_back('{ex: m, cnt: m_cnt});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, "/sb_empty"}, 512'd1, 512'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, "/ex"}, {221'd0, obs_ex()}, {221'd0, e.ex});
      check_eq({tag, "/cnt"}, {480'd0, bcnt}, {480'd0, e.cnt});
    end
  endtask

  function automatic id_t mk(input logic v, input logic [10:0] op, input logic [1:0] aop,
                             input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                             input logic [5:0] ctl, input logic urm);
    id_t d;
    d = '0;
    d.valid = v; d.opcode = op; d.alu_op = aop; d.rn = rn; d.rm = rm; d.rd = rd;
    {d.alu_src, d.mem_read, d.mem_write, d.mem_to_reg, d.reg_write, d.branch} = ctl;
    d.uses_rm = urm;
    return d;
  endfunction

  function automatic id_t rand_id();
    id_t d;
    logic [4:0] pick [4];
    pick[0] = 5'd5; pick[1] = 5'd7; pick[2] = 5'd31; pick[3] = 5'($urandom);
    d = id_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom});
    d.rd = pick[$urandom_range(0, 3)];
    d.rn = pick[$urandom_range(0, 3)];
    d.rm = pick[$urandom_range(0, 3)];
    d.valid = ($urandom_range(0, 7) != 0);
    return d;
  endfunction

  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpCbz  = 11'b10110100000;

  id_t add_i, ldur_i;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; flush_s = 1'b0;
    id_z = '0;
    id = '1;
    m = '0; m_cnt = 0;
    #3;
    check_eq("rst_ex", {221'd0, obs_ex()}, 512'd0);
    check_eq("rst_hz", {511'd0, hazard}, 512'd0);
    check_eq("rst_cnt", {480'd0, bcnt}, 512'd0);
    @(negedge clk);
    reset = 1'b0;

    // Pass-through ADD
    add_i = mk(1'b1, OpAdd, 2'b10, 5'd1, 5'd2, 5'd3, 6'b000010, 1'b1);
    add_i.rd1 = 64'd2; add_i.rd2 = 64'd3; add_i.imm = 64'd1; add_i.pc = 64'd16;
    id = add_i;
    step("add");
    check_eq("add_valid", {511'd0, ex_valid}, {511'd0, 1'b1});
    check_eq("add_aluop", {510'd0, alu_op}, {510'd0, 2'b10});

    // Load-use on Rn, then capture after the bubble
    ldur_i = mk(1'b1, OpLdur, 2'b00, 5'd2, 5'd0, 5'd5, 6'b110110, 1'b0);
    ldur_i.imm = 64'd8; ldur_i.pc = 64'd20;
    id = ldur_i;  step("ldur5");
    add_i.rn = 5'd5; add_i.pc = 64'd24;
    id = add_i;   step("lu_bubble");
    check_eq("lu_bubble_cnt", {480'd0, bcnt}, {480'd0, 32'd1});
    step("lu_capture");

    // Rm only matters when the instruction reads it
    ldur_i.rd = 5'd7;
    id = ldur_i;  step("ldur7a");
    id = mk(1'b1, OpAdd, 2'b10, 5'd1, 5'd7, 5'd9, 6'b000010, 1'b0);
    step("rm_unused");
    id = ldur_i;  step("ldur7b");
    id = mk(1'b1, OpAdd, 2'b10, 5'd1, 5'd7, 5'd9, 6'b000010, 1'b1);
    step("rm_bubble");
    step("rm_capture");

    // XZR destination never stalls
    ldur_i.rd = 5'd31;
    id = ldur_i;  step("ldur31");
    id = mk(1'b1, OpAdd, 2'b10, 5'd31, 5'd31, 5'd4, 6'b000010, 1'b1);
    step("xzr_nostall");

    // Non-valid entry passes controls through, not a bubble
    id = mk(1'b0, OpAdd, 2'b11, 5'd3, 5'd4, 5'd6, 6'b101010, 1'b1);
    step("invalid_pass");

    // Stall hold of CBZ
    id = mk(1'b1, OpCbz, 2'b01, 5'd0, 5'd4, 5'd0, 6'b000001, 1'b1);
    id.rd2 = 64'd3; id.pc = 64'd40;
    step("cbz");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id = rand_id();
      step($sformatf("stall%0d", i));
    end
    stall = 1'b0;

    // Flush and stall together while a load-use hazard is present
    ldur_i.rd = 5'd5;
    id = ldur_i;  step("ldur5b");
    id = add_i;   flush = 1'b1; stall = 1'b1;
    step("flush_stall");
    flush = 1'b0; stall = 1'b0;
    id = add_i;   step("after_flush");
    flush = 1'b1; step("flush_only");
    flush = 1'b0;

    // Random mix
    for (int i = 0; i < 40; i++) begin
      id = rand_id();
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step($sformatf("rnd%0d", i));
    end
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset with a pending hazard
    id = ldur_i;  step("ldur5c");
    id = add_i;
    #1;
    check_eq("pre_rst_hz", {511'd0, hazard}, {511'd0, model_hazard()});
    reset = 1'b1;
    #1;
    check_eq("mid_rst_ex", {221'd0, obs_ex()}, 512'd0);
    check_eq("mid_rst_hz", {511'd0, hazard}, 512'd0);
    check_eq("mid_rst_cnt", {480'd0, bcnt}, 512'd0);
    m = '0; m_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    step("post_rst");

    // Saturation on the 2-bit counter instance
    check_eq("sat0", {510'd0, s_cnt}, 512'd0);
    flush_s = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("sat%0d", k), {510'd0, s_cnt}, (k > 3) ? 512'd3 : 512'(k));
    end
    flush_s = 1'b0;
    @(posedge clk);
    #1;
    check_eq("sat_hold", {510'd0, s_cnt}, 512'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
